// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// The request fields stay stable for as long as mem_req is held.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-command load/store stage: one req/ack bus transaction per command,
// with load-data lane alignment/extension and a one-cycle register write.
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      is_load,
    input  logic [1:0]                size,
    input  logic                      sign_ext,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    input  logic [3:0]                dest,
    load_store_unit_if.master         mem,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      write_en,
    output logic [3:0]                write_dest,
    output logic [31:0]               write_in
);
    typedef enum logic [1:0] {IDLE, REQ, WB, FIN} state_e;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          load_q, load_d;
    logic          sext_q, sext_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [3:0]    dest_q, dest_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          bad_cmd;
    logic          timeout_hit;
    logic [31:0]   lane;
    logic [31:0]   ext;
    logic [3:0]    be;
    logic [31:0]   wdata;

    assign bad_cmd     = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                         (size == 2'b10 && addr[1:0] != 2'b00);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Shift the addressed lane down to bit 0, then extend by access size.
    always_comb begin
        lane = mem.mem_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   ext = {{24{sext_q & lane[7]}}, lane[7:0]};
            2'b01:   ext = {{16{sext_q & lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        case (size_q)
            2'b00:   wdata = {4{sdata_q[7:0]}};
            2'b01:   wdata = {2{sdata_q[15:0]}};
            default: wdata = sdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !bad_cmd) state_d = REQ;
            REQ: begin
                if (mem.mem_ack)      state_d = load_q ? WB : FIN;
                else if (timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command is latched only in IDLE, so a start while busy is dropped.
    always_comb begin
        load_d  = load_q;
        sext_d  = sext_q;
        size_d  = size_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        dest_d  = dest_q;
        rdata_d = rdata_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        if (state_q == IDLE && start) begin
            load_d  = is_load;
            sext_d  = sign_ext;
            size_d  = size;
            addr_d  = addr;
            sdata_d = store_data;
            dest_d  = dest;
            err_d   = bad_cmd;
        end
        if (state_q == REQ) begin
            if (mem.mem_ack)      rdata_d = ext;
            else if (timeout_hit) err_d   = 1'b1;
            else                  cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            sdata_q <= '0;
            dest_q  <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
            sext_q  <= sext_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            dest_q  <= dest_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus fields are gated to REQ so they read zero while idle or in reset.
    always_comb begin
        busy          = (state_q != IDLE);
        mem.mem_req   = (state_q == REQ);
        mem.mem_we    = (state_q == REQ) && !load_q;
        mem.mem_addr  = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem.mem_wdata = (state_q == REQ) ? wdata : 32'h0;
        mem.mem_be    = (state_q == REQ) ? be : 4'b0000;
        done          = (state_q == WB) || (state_q == FIN);
        err           = err_q;
        write_en      = (state_q == WB);
        write_dest    = (state_q == WB) ? dest_q : 4'b1111;
        write_in      = (state_q == WB) ? rdata_q : 32'h0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed commands push expected bus
// transactions and completion pulses; negedge monitors pop and compare.
module tb_load_store_unit;
    localparam int TO = 4;

    typedef struct {
        bit          is_err;
        bit          wen;
        logic [3:0]  wdest;
        logic [31:0] win;
        int          at;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        int          len;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_load, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, store_data;
    logic [3:0]  dest;
    logic        busy, done, err, write_en;
    logic [3:0]  write_dest;
    logic [31:0] write_in;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .size(size),
        .sign_ext(sign_ext), .addr(addr), .store_data(store_data), .dest(dest),
        .mem(bus), .busy(busy), .done(done), .err(err), .write_en(write_en),
        .write_dest(write_dest), .write_in(write_in)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_fail = 0;
    int    cyc = 0;
    resp_t resp_q[$];
    bus_t  bus_q[$];

    int          ack_dly = 0;
    logic [31:0] rd_val = 32'h0;
    bit          force_ack = 1'b0;
    int          wcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: ack after ack_dly waiting cycles; ack_dly<0 never acks.
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (wcnt == ack_dly) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd_val;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end
            wcnt++;
        end else begin
            bus.mem_ack   = force_ack;
            bus.mem_rdata = 32'hA5A5_A5A5;
            wcnt = 0;
        end
    end

    // Bus monitor: one expected entry per mem_req burst, fields held, length checked.
    bit   in_txn = 1'b0;
    int   req_len = 0;
    bus_t cur;
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (!in_txn) begin
                if (bus_q.size() == 0) chk("unexpected_mem_req", 1, 0);
                else cur = bus_q.pop_front();
                in_txn  = 1'b1;
                req_len = 0;
            end
            req_len++;
            chk("mem_we", bus.mem_we, cur.we);
            chk("mem_addr", bus.mem_addr, cur.addr);
            chk("mem_be", bus.mem_be, cur.be);
            if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wd);
        end else if (in_txn) begin
            chk("mem_req_cycles", req_len, cur.len);
            in_txn = 1'b0;
        end
    end

    // Completion monitor.
    resp_t r;
    always @(negedge clk) begin
        if (!write_en && (write_dest !== 4'b1111 || write_in !== 32'h0))
            chk("idle_write_port", {write_dest, write_in[27:0]}, {4'b1111, 28'h0});
        if (done || err) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_done_err", {done, err}, 0);
            end else begin
                r = resp_q.pop_front();
                chk("err", err, r.is_err);
                chk("done", done, !r.is_err);
                chk("write_en", write_en, r.wen);
                chk("write_dest", write_dest, r.wdest);
                chk("write_in", write_in, r.win);
                chk("latency_cycle", cyc, r.at);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("busy_timeout", busy, 0);
    endtask

    task automatic issue(input bit ld, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] sd, input logic [3:0] dst,
                         input int dly, input logic [31:0] rd,
                         input bit bad, input logic [31:0] exp_win,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input bit spurious);
        resp_t e;
        bus_t  b;
        is_load = ld; size = sz; sign_ext = sx; addr = a; store_data = sd; dest = dst;
        ack_dly = dly; rd_val = rd;
        start = 1'b1;
        if (bad) begin
            e = '{1'b1, 1'b0, 4'b1111, 32'h0, cyc + 1};
        end else begin
            b = '{!ld, {a[31:2], 2'b00}, exp_wd, exp_be, (dly < 0) ? TO : dly + 1};
            bus_q.push_back(b);
            if (dly < 0) e = '{1'b1, 1'b0, 4'b1111, 32'h0, cyc + 1 + TO};
            else e = '{1'b0, ld, ld ? dst : 4'b1111, ld ? exp_win : 32'h0, cyc + 2 + dly};
        end
        resp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (spurious) begin
            // Different command presented while busy; must not be latched or queued.
            is_load = 1'b0; size = 2'b10; addr = 32'h500; store_data = 32'hFFFF_FFFF;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'h0; store_data = 32'h0; dest = 4'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done_err_wen", {done, err, write_en}, 0);
        chk("rst_write_dest", write_dest, 4'b1111);
        chk("rst_write_in", write_in, 0);
        chk("rst_mem_req_we_be", {bus.mem_req, bus.mem_we, bus.mem_be}, 0);
        chk("rst_mem_addr_wdata", bus.mem_addr | bus.mem_wdata, 0);
        reset = 1'b0;
        @(negedge clk);

        //    ld    sz     sx  addr          store_data    dst  dly rdata         bad win           be       wdata         spur
        issue(1, 2'b10, 0, 32'h0000_0100, 32'h0,        3,   1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        0);
        issue(1, 2'b00, 1, 32'h0000_0103, 32'h0,        5,   0, 32'h8012_3456, 0, 32'hFFFF_FF80, 4'b1000, 32'h0,        0);
        issue(1, 2'b00, 0, 32'h0000_0103, 32'h0,        5,   0, 32'h8012_3456, 0, 32'h0000_0080, 4'b1000, 32'h0,        0);
        issue(0, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 7,  2, 32'h0,         0, 32'h0,         4'b1100, 32'hABCD_ABCD, 0);
        issue(1, 2'b10, 0, 32'h0000_0101, 32'h0,        3,   0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,        0);
        issue(1, 2'b11, 0, 32'h0000_0100, 32'h0,        3,   0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,        0);
        issue(1, 2'b01, 0, 32'h0000_0103, 32'h0,        3,   0, 32'h0,         1, 32'h0,         4'b0000, 32'h0,        0);
        issue(1, 2'b01, 0, 32'h0000_0102, 32'h0,        1,   0, 32'h8765_4321, 0, 32'h0000_8765, 4'b1100, 32'h0,        0);
        issue(1, 2'b01, 1, 32'h0000_0100, 32'h0,        2,   3, 32'h0000_F00D, 0, 32'hFFFF_F00D, 4'b0011, 32'h0,        0);
        issue(1, 2'b00, 1, 32'h0000_0101, 32'h0,        4,   0, 32'h0000_7F00, 0, 32'h0000_007F, 4'b0010, 32'h0,        0);
        issue(0, 2'b00, 0, 32'h0000_0101, 32'h0000_00AB, 0,  0, 32'h0,         0, 32'h0,         4'b0010, 32'hABAB_ABAB, 0);
        issue(0, 2'b10, 0, 32'h0000_0400, 32'hCAFE_F00D, 0,  1, 32'h0,         0, 32'h0,         4'b1111, 32'hCAFE_F00D, 0);
        issue(0, 2'b01, 0, 32'h0000_0200, 32'h1234_ABCD, 0,  0, 32'h0,         0, 32'h0,         4'b0011, 32'hABCD_ABCD, 0);
        // Timeout, then a fresh load to PC (dest 9) passes straight through.
        issue(1, 2'b10, 0, 32'h0000_0300, 32'h0,        6,  -1, 32'h0,         0, 32'h0,         4'b1111, 32'h0,        0);
        issue(1, 2'b10, 0, 32'h0000_0304, 32'h0,        9,   0, 32'h1122_3344, 0, 32'h1122_3344, 4'b1111, 32'h0,        0);
        // Start while busy is dropped.
        issue(1, 2'b01, 1, 32'h0000_0106, 32'h0,       10,   2, 32'h9ABC_0000, 0, 32'hFFFF_9ABC, 4'b1100, 32'h0,        1);

        // Stray ack while idle must not produce anything.
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        chk("stray_ack_busy", busy, 0);

        // Reset during REQ: bus drops at once, no completion pulse.
        is_load = 1'b1; size = 2'b10; addr = 32'h0000_0700; dest = 4'h2;
        ack_dly = 3; rd_val = 32'h5555_AAAA;
        bus_q.push_back('{1'b0, 32'h0000_0700, 32'h0, 4'b1111, 2});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_mem_req", bus.mem_req, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_write_port", {write_en, done, write_dest}, {2'b00, 4'b1111});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1, 2'b00, 0, 32'h0000_0702, 32'h0, 1, 0, 32'h00C3_0000, 0, 32'h0000_00C3, 4'b0100, 32'h0, 0);

        repeat (4) @(negedge clk);
        chk("pending_resp", resp_q.size(), 0);
        chk("pending_bus", bus_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
